axi_lite_master_rw: RTL and testbench
=====================================

Name: axi_lite_master_rw

Overview:
- Parametrised AXI4-Lite master bridging a simple module-side request port to all five AXI-Lite channels.
- Read and write paths are independent: one outstanding read and one outstanding write at a time, each with its own FSM.
- Adds configurable widths, byte strobes, PROT and response-error reporting, plus a done/busy handshake back to the requesting module.

Parameters:
ADDR_WIDTH  32  address width of module port and AXADDR
DATA_WIDTH  32  data width; legal values 32 or 64
PROT_VAL    3'b000  constant driven on ARPROT/AWPROT

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  asynchronous reset, active-high
MOD_2_M_RRQST  in  1  read request; sampled only while read FSM idle
MOD_2_M_RADDR  in  ADDR_WIDTH  read address, captured with request
M_2_MOD_RDATA  out  DATA_WIDTH  read data, held until next read completes
M_2_MOD_RDONE  out  1  one-cycle pulse: read finished
M_2_MOD_RERR  out  1  RRESP[1] of last read, valid with RDONE, held
M_2_MOD_RBUSY  out  1  read FSM not idle
MOD_2_M_WRQST  in  1  write request; sampled only while write FSM idle
MOD_2_M_WADDR  in  ADDR_WIDTH  write address
MOD_2_M_WDATA  in  DATA_WIDTH  write data
MOD_2_M_WSTRB  in  DATA_WIDTH/8  byte strobes
M_2_MOD_WDONE  out  1  one-cycle pulse: write response received
M_2_MOD_WERR  out  1  BRESP[1] of last write, valid with WDONE, held
M_2_MOD_WBUSY  out  1  write FSM not idle
ARADDR/ARPROT/ARVALID out, ARREADY in  ADDR_WIDTH/3/1/1  read address channel
RDATA/RRESP/RVALID in, RREADY out  DATA_WIDTH/2/1/1  read data channel
AWADDR/AWPROT/AWVALID out, AWREADY in  ADDR_WIDTH/3/1/1  write address channel
WDATA/WSTRB/WVALID out, WREADY in  DATA_WIDTH/(DATA_WIDTH/8)/1/1  write data channel
BRESP/BVALID in, BREADY out  2/1/1  write response channel

Behaviour:
- Reset: all outputs 0, both FSMs idle. AXPROT always PROT_VAL. Reset mid-transaction abandons it immediately; no done pulse.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: MOD_2_M_RRQST=1 at edge N registers ARADDR and sets ARVALID=1 from N+1; go R_ADDR.
  - R_ADDR: ARVALID and ARADDR held stable until ARVALID&ARREADY. On that edge: ARVALID<=0, ARADDR<=0, RREADY<=1; go R_DATA.
  - R_DATA: on RVALID&RREADY, register RDATA into M_2_MOD_RDATA and RRESP[1] into RERR, RREADY<=0, RDONE pulses 1 cycle; go R_IDLE.
  - RVALID outside R_DATA is ignored.
- Write FSM W_IDLE -> W_SEND -> W_RESP -> W_IDLE.
  - W_IDLE: WRQST at edge N registers AWADDR/WDATA/WSTRB and sets AWVALID=WVALID=1 from N+1.
  - W_SEND: AWVALID drops on its own handshake edge and WVALID drops on its own; they complete in either order or in the same cycle. Payloads are held while the matching VALID is high and cleared to 0 on handshake. When both channels are done (including same-edge completion), BREADY<=1; go W_RESP.
  - W_RESP: on BVALID&BREADY, BREADY<=0, WERR<=BRESP[1], WDONE pulses 1 cycle; go W_IDLE.
- BUSY = FSM != idle, registered.
- A request asserted while BUSY is ignored and not queued. A request high on the same edge as DONE is ignored, because the FSM is not yet idle. A held-high request restarts a new transaction the cycle after return to idle.
- Read and write run concurrently. Simultaneous RRQST and WRQST both start on the same edge. There is no ordering between them.
- VALID never depends combinationally on READY. All outputs are registered.
- Minimum latency with READY always high and a zero-wait slave: request edge N, ARVALID N+1, RREADY N+2, RVALID sampled N+2 or later, RDONE the cycle after the data handshake.

Test Plan:
- Reset mid-read: RRQST addr 0x10 and ARREADY held 0, then assert ARESET -> ARVALID=0, RBUSY=0, RDONE never pulses. Repeat as mid-write: AWVALID=0, WVALID=0, WBUSY=0, WDONE never pulses.
- Basic read: RRQST addr 0x0000_0040; ARREADY 2 cycles late; RDATA 0xDEADBEEF, RRESP 00 -> ARADDR=0x40 stable until handshake; RDATA=0xDEADBEEF; RDONE one cycle; RERR=0.
- Write with AW before W: WRQST addr 0x80, data 0x12345678, strb 4'b0011; AWREADY at cycle 1, WREADY at cycle 4; BRESP 10 -> AWVALID drops after cycle 1, WVALID drops after cycle 4; BREADY rises only after both; WDONE pulse with WERR=1.
- Write with W before AW, then same-cycle AW/W handshake -> BREADY asserted exactly once per transaction in both cases.
- Concurrent read and write, same-edge requests -> both complete independently with correct data. A second RRQST issued while RBUSY=1 is ignored: exactly one AR handshake.
- DATA_WIDTH=64 build: WSTRB 8'hF0, WDATA 0x1122334455667788 -> driven unchanged on WDATA/WSTRB.

Source files
------------

// File: rtl/axi_lite_master_rw.sv
// AXI4-Lite master: turns single-beat module read/write requests into AXI-Lite
// transactions, with independent read and write FSMs.
`timescale 1ns/1ps
module axi_lite_master_rw #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  PROT_VAL   = 3'b000
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // module-side read port
    input  logic                      MOD_2_M_RRQST,
    input  logic [ADDR_WIDTH-1:0]     MOD_2_M_RADDR,
    output logic [DATA_WIDTH-1:0]     M_2_MOD_RDATA,
    output logic                      M_2_MOD_RDONE,
    output logic                      M_2_MOD_RERR,
    output logic                      M_2_MOD_RBUSY,
    // module-side write port
    input  logic                      MOD_2_M_WRQST,
    input  logic [ADDR_WIDTH-1:0]     MOD_2_M_WADDR,
    input  logic [DATA_WIDTH-1:0]     MOD_2_M_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   MOD_2_M_WSTRB,
    output logic                      M_2_MOD_WDONE,
    output logic                      M_2_MOD_WERR,
    output logic                      M_2_MOD_WBUSY,
    // AXI read address / data
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t r_state, r_state_n;
    w_state_t w_state, w_state_n;

    logic [ADDR_WIDTH-1:0] araddr_n, awaddr_n;
    logic                  arvalid_n, rready_n, rdone_n, rerr_n;
    logic [DATA_WIDTH-1:0] rdata_n, wdata_n;
    logic [STRB_WIDTH-1:0] wstrb_n;
    logic                  awvalid_n, wvalid_n, bready_n, wdone_n, werr_n;
    logic                  aw_hs, w_hs;
    logic                  unused_resp;

    // Only the error bit of each response is reported.
    assign unused_resp = ^{RRESP[0], BRESP[0]};

    assign ARPROT = PROT_VAL;
    assign AWPROT = PROT_VAL;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Read path next-state and next-output logic
    always_comb begin
        r_state_n = r_state;
        araddr_n  = ARADDR;
        arvalid_n = ARVALID;
        rready_n  = RREADY;
        rdata_n   = M_2_MOD_RDATA;
        rerr_n    = M_2_MOD_RERR;
        rdone_n   = 1'b0;
        case (r_state)
            R_IDLE: if (MOD_2_M_RRQST) begin
                araddr_n  = MOD_2_M_RADDR;
                arvalid_n = 1'b1;
                r_state_n = R_ADDR;
            end
            R_ADDR: if (ARVALID && ARREADY) begin
                arvalid_n = 1'b0;
                araddr_n  = '0;
                rready_n  = 1'b1;
                r_state_n = R_DATA;
            end
            R_DATA: if (RVALID && RREADY) begin
                rdata_n   = RDATA;
                rerr_n    = RRESP[1];
                rready_n  = 1'b0;
                rdone_n   = 1'b1;
                r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            ARADDR        <= '0;
            ARVALID       <= 1'b0;
            RREADY        <= 1'b0;
            M_2_MOD_RDATA <= '0;
            M_2_MOD_RERR  <= 1'b0;
            M_2_MOD_RDONE <= 1'b0;
            M_2_MOD_RBUSY <= 1'b0;
        end else begin
            r_state       <= r_state_n;
            ARADDR        <= araddr_n;
            ARVALID       <= arvalid_n;
            RREADY        <= rready_n;
            M_2_MOD_RDATA <= rdata_n;
            M_2_MOD_RERR  <= rerr_n;
            M_2_MOD_RDONE <= rdone_n;
            M_2_MOD_RBUSY <= (r_state_n != R_IDLE);
        end
    end

    // Write path: AW and W retire independently; B is accepted once both have.
    always_comb begin
        w_state_n = w_state;
        awaddr_n  = AWADDR;
        awvalid_n = AWVALID;
        wdata_n   = WDATA;
        wstrb_n   = WSTRB;
        wvalid_n  = WVALID;
        bready_n  = BREADY;
        werr_n    = M_2_MOD_WERR;
        wdone_n   = 1'b0;
        case (w_state)
            W_IDLE: if (MOD_2_M_WRQST) begin
                awaddr_n  = MOD_2_M_WADDR;
                wdata_n   = MOD_2_M_WDATA;
                wstrb_n   = MOD_2_M_WSTRB;
                awvalid_n = 1'b1;
                wvalid_n  = 1'b1;
                w_state_n = W_SEND;
            end
            W_SEND: begin
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    awaddr_n  = '0;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    wdata_n  = '0;
                    wstrb_n  = '0;
                end
                if ((!AWVALID || aw_hs) && (!WVALID || w_hs)) begin
                    bready_n  = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: if (BVALID && BREADY) begin
                bready_n  = 1'b0;
                werr_n    = BRESP[1];
                wdone_n   = 1'b1;
                w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            AWADDR        <= '0;
            AWVALID       <= 1'b0;
            WDATA         <= '0;
            WSTRB         <= '0;
            WVALID        <= 1'b0;
            BREADY        <= 1'b0;
            M_2_MOD_WERR  <= 1'b0;
            M_2_MOD_WDONE <= 1'b0;
            M_2_MOD_WBUSY <= 1'b0;
        end else begin
            w_state       <= w_state_n;
            AWADDR        <= awaddr_n;
            AWVALID       <= awvalid_n;
            WDATA         <= wdata_n;
            WSTRB         <= wstrb_n;
            WVALID        <= wvalid_n;
            BREADY        <= bready_n;
            M_2_MOD_WERR  <= werr_n;
            M_2_MOD_WDONE <= wdone_n;
            M_2_MOD_WBUSY <= (w_state_n != W_IDLE);
        end
    end

endmodule

// File: tb/tb_axi_lite_master_rw.sv
// Directed bench for axi_lite_master_rw: a 32-bit instance with non-zero PROT
// and a 64-bit instance; completions are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_axi_lite_master_rw;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned XW = 64;
    localparam logic [2:0]  PROT = 3'b010;

    typedef struct packed { logic [63:0] data; logic err; } rd_exp_t;

    logic ACLK = 1'b0;
    logic ARESET;

    // 32-bit instance signals
    logic          rrqst, rdone, rerr, rbusy, wrqst, wdone, werr, wbusy;
    logic [AW-1:0] raddr, waddr, araddr, awaddr;
    logic [DW-1:0] rdata_m, wdata_m, rdata, wdata;
    logic [3:0]    wstrb_m, wstrb;
    logic [2:0]    arprot, awprot;
    logic          arvalid, arready, rvalid, rready, awvalid, awready;
    logic          wvalid, wready, bvalid, bready;
    logic [1:0]    rresp, bresp;

    // 64-bit instance signals
    logic          xrrqst, xrdone, xrerr, xrbusy, xwrqst, xwdone, xwerr, xwbusy;
    logic [AW-1:0] xraddr, xwaddr, xaraddr, xawaddr;
    logic [XW-1:0] xrdata_m, xwdata_m, xrdata, xwdata;
    logic [7:0]    xwstrb_m, xwstrb;
    logic [2:0]    xarprot, xawprot;
    logic          xarvalid, xarready, xrvalid, xrready, xawvalid, xawready;
    logic          xwvalid, xwready, xbvalid, xbready;
    logic [1:0]    xrresp, xbresp;

    int checks = 0;
    int errors = 0;
    int rdone_cnt = 0, wdone_cnt = 0, ar_hs = 0, bready_rise = 0;
    logic bready_prev = 1'b0;
    rd_exp_t rd_q[$], xrd_q[$];
    logic    wr_q[$], xwr_q[$];
    rd_exp_t re, xre;
    logic    we, xwe;

    axi_lite_master_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_VAL(PROT)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .MOD_2_M_RRQST(rrqst), .MOD_2_M_RADDR(raddr), .M_2_MOD_RDATA(rdata_m),
        .M_2_MOD_RDONE(rdone), .M_2_MOD_RERR(rerr), .M_2_MOD_RBUSY(rbusy),
        .MOD_2_M_WRQST(wrqst), .MOD_2_M_WADDR(waddr), .MOD_2_M_WDATA(wdata_m),
        .MOD_2_M_WSTRB(wstrb_m), .M_2_MOD_WDONE(wdone), .M_2_MOD_WERR(werr),
        .M_2_MOD_WBUSY(wbusy),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready)
    );

    axi_lite_master_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(XW)) dut64 (
        .ACLK(ACLK), .ARESET(ARESET),
        .MOD_2_M_RRQST(xrrqst), .MOD_2_M_RADDR(xraddr), .M_2_MOD_RDATA(xrdata_m),
        .M_2_MOD_RDONE(xrdone), .M_2_MOD_RERR(xrerr), .M_2_MOD_RBUSY(xrbusy),
        .MOD_2_M_WRQST(xwrqst), .MOD_2_M_WADDR(xwaddr), .MOD_2_M_WDATA(xwdata_m),
        .MOD_2_M_WSTRB(xwstrb_m), .M_2_MOD_WDONE(xwdone), .M_2_MOD_WERR(xwerr),
        .M_2_MOD_WBUSY(xwbusy),
        .ARADDR(xaraddr), .ARPROT(xarprot), .ARVALID(xarvalid), .ARREADY(xarready),
        .RDATA(xrdata), .RRESP(xrresp), .RVALID(xrvalid), .RREADY(xrready),
        .AWADDR(xawaddr), .AWPROT(xawprot), .AWVALID(xawvalid), .AWREADY(xawready),
        .WDATA(xwdata), .WSTRB(xwstrb), .WVALID(xwvalid), .WREADY(xwready),
        .BRESP(xbresp), .BVALID(xbvalid), .BREADY(xbready)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while ((rd_q.size() + wr_q.size() + xrd_q.size() + xwr_q.size()) != 0 && i < 50) begin
            tick();
            i++;
        end
        chk(tag, 64'(rd_q.size() + wr_q.size() + xrd_q.size() + xwr_q.size()), 64'd0);
    endtask

    // Handshake bookkeeping from pre-edge values
    always @(posedge ACLK) begin
        if (arvalid && arready) ar_hs++;
        if (bready && !bready_prev) bready_rise++;
        bready_prev = bready;
    end

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge ACLK) begin
        if (rdone) begin
            rdone_cnt++;
            if (rd_q.size() == 0) chk("rd_spurious_done", 64'd1, 64'd0);
            else begin
                re = rd_q.pop_front();
                chk("rd_data", 64'(rdata_m), re.data);
                chk("rd_err", 64'(rerr), 64'(re.err));
            end
        end
        if (wdone) begin
            wdone_cnt++;
            if (wr_q.size() == 0) chk("wr_spurious_done", 64'd1, 64'd0);
            else begin
                we = wr_q.pop_front();
                chk("wr_err", 64'(werr), 64'(we));
            end
        end
        if (xrdone) begin
            if (xrd_q.size() == 0) chk("x_rd_spurious_done", 64'd1, 64'd0);
            else begin
                xre = xrd_q.pop_front();
                chk("x_rd_data", xrdata_m, xre.data);
                chk("x_rd_err", 64'(xrerr), 64'(xre.err));
            end
        end
        if (xwdone) begin
            if (xwr_q.size() == 0) chk("x_wr_spurious_done", 64'd1, 64'd0);
            else begin
                xwe = xwr_q.pop_front();
                chk("x_wr_err", 64'(xwerr), 64'(xwe));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ARESET = 1'b1;
        {rrqst, wrqst, arready, rvalid, awready, wready, bvalid} = '0;
        raddr = '0; waddr = '0; wdata_m = '0; wstrb_m = '0; rdata = '0; rresp = '0; bresp = '0;
        {xrrqst, xwrqst, xarready, xrvalid, xawready, xwready, xbvalid} = '0;
        xraddr = '0; xwaddr = '0; xwdata_m = '0; xwstrb_m = '0; xrdata = '0; xrresp = '0; xbresp = '0;
        tick(2);
        ARESET = 1'b0;
        tick();

        // Reset state
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_busy", 64'({rbusy, wbusy, rdone, wdone}), 64'd0);
        chk("rst_rdata", 64'(rdata_m), 64'd0);
        chk("arprot", 64'(arprot), 64'(PROT));
        chk("awprot", 64'(awprot), 64'(PROT));

        // Reset in the middle of a read
        rrqst = 1'b1; raddr = 32'h10;
        tick();
        rrqst = 1'b0;
        chk("mr_arvalid", 64'(arvalid), 64'd1);
        chk("mr_araddr", 64'(araddr), 64'h10);
        chk("mr_rbusy", 64'(rbusy), 64'd1);
        tick(2);
        n = rdone_cnt;
        ARESET = 1'b1;
        #1;
        chk("mr_rst_arvalid", 64'(arvalid), 64'd0);
        chk("mr_rst_rbusy", 64'(rbusy), 64'd0);
        tick();
        ARESET = 1'b0;
        tick(3);
        chk("mr_no_rdone", 64'(rdone_cnt), 64'(n));

        // Reset in the middle of a write
        wrqst = 1'b1; waddr = 32'h20; wdata_m = 32'hAAAA5555; wstrb_m = 4'hF;
        tick();
        wrqst = 1'b0;
        chk("mw_valids", 64'({awvalid, wvalid, wbusy}), 64'h7);
        n = wdone_cnt;
        ARESET = 1'b1;
        #1;
        chk("mw_rst_valids", 64'({awvalid, wvalid, wbusy}), 64'h0);
        tick();
        ARESET = 1'b0;
        tick(3);
        chk("mw_no_wdone", 64'(wdone_cnt), 64'(n));

        // Stray RVALID while idle is ignored
        rvalid = 1'b1; rdata = 32'hBAD0BAD0;
        tick(2);
        rvalid = 1'b0;
        chk("idle_rvalid_ignored", 64'(rdone_cnt), 64'(n));

        // Basic read with ARREADY two cycles late
        n = ar_hs;
        rd_q.push_back('{64'hDEADBEEF, 1'b0});
        rrqst = 1'b1; raddr = 32'h40;
        tick();
        rrqst = 1'b0;
        chk("rd_arvalid", 64'(arvalid), 64'd1);
        chk("rd_araddr", 64'(araddr), 64'h40);
        tick();
        chk("rd_araddr_hold1", 64'(araddr), 64'h40);
        tick();
        chk("rd_araddr_hold2", 64'({arvalid, araddr}), {31'd0, 1'b1, 32'h40});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rd_after_ar", 64'({arvalid, rready, araddr}), {30'd0, 2'b01, 32'h0});
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("rd_done_pulse", 64'({rdone, rready}), 64'h2);
        tick();
        chk("rd_done_one_cycle", 64'({rdone, rbusy}), 64'h0);
        chk("rd_data_held", 64'(rdata_m), 64'hDEADBEEF);
        chk("rd_one_ar", 64'(ar_hs), 64'(n + 1));
        wait_drain("rd_basic_drain");

        // Write, AW accepted before W, SLVERR response
        wr_q.push_back(1'b1);
        wrqst = 1'b1; waddr = 32'h80; wdata_m = 32'h12345678; wstrb_m = 4'b0011;
        tick();
        wrqst = 1'b0;
        chk("wr_bus", {awvalid, wvalid, awaddr[29:0], wdata}, {1'b1, 1'b1, 30'h80, 32'h12345678});
        chk("wr_strb", 64'(wstrb), 64'h3);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("wr_aw_done", 64'({awvalid, wvalid, bready, awaddr}), {29'd0, 3'b010, 32'h0});
        tick(2);
        chk("wr_w_pending", 64'({wvalid, bready, wdata}), {30'd0, 2'b10, 32'h12345678});
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("wr_w_done", 64'({wvalid, bready, wstrb, wdata}), {26'd0, 2'b01, 4'h0, 32'h0});
        bresp = 2'b10; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("wr_done_pulse", 64'({wdone, werr, bready}), 64'h6);
        tick();
        chk("wr_done_one_cycle", 64'({wdone, wbusy, werr}), 64'h1);
        wait_drain("wr_awfirst_drain");

        // Write, W accepted before AW
        n = bready_rise;
        wr_q.push_back(1'b0);
        wrqst = 1'b1; waddr = 32'h84; wdata_m = 32'hCAFEF00D; wstrb_m = 4'hF;
        tick();
        wrqst = 1'b0; wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("wf_w_done", 64'({wvalid, awvalid, bready}), 64'h2);
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("wf_aw_done", 64'({awvalid, bready}), 64'h1);
        bresp = 2'b00; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("wf_done", 64'({wdone, werr}), 64'h2);
        tick();
        chk("wf_bready_once", 64'(bready_rise), 64'(n + 1));
        wait_drain("wr_wfirst_drain");

        // Write, AW and W accepted on the same edge
        n = bready_rise;
        wr_q.push_back(1'b0);
        wrqst = 1'b1; waddr = 32'h88; wdata_m = 32'h0F0F0F0F; wstrb_m = 4'h5;
        tick();
        wrqst = 1'b0; awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("sc_both_done", 64'({awvalid, wvalid, bready}), 64'h1);
        tick(2);
        chk("sc_bready_hold", 64'(bready), 64'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("sc_done", 64'(wdone), 64'd1);
        tick();
        chk("sc_bready_once", 64'(bready_rise), 64'(n + 1));
        wait_drain("wr_same_drain");

        // Concurrent read and write; a second read request while busy is dropped
        n = ar_hs;
        rd_q.push_back('{64'h5A5AA5A5, 1'b1});
        wr_q.push_back(1'b0);
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        rvalid = 1'b1; rdata = 32'h5A5AA5A5; rresp = 2'b10;
        bvalid = 1'b1; bresp = 2'b00;
        rrqst = 1'b1; raddr = 32'hC0;
        wrqst = 1'b1; waddr = 32'hC4; wdata_m = 32'h77; wstrb_m = 4'h1;
        tick();
        wrqst = 1'b0;
        chk("cc_both_busy", 64'({rbusy, wbusy, arvalid, awvalid}), 64'hF);
        tick();
        rrqst = 1'b0;
        wait_drain("cc_drain");
        {arready, awready, wready, rvalid, bvalid} = '0;
        tick(2);
        chk("cc_one_ar", 64'(ar_hs), 64'(n + 1));
        chk("cc_idle", 64'({rbusy, wbusy}), 64'h0);

        // 64-bit build: wide data and strobes pass through unchanged
        xwr_q.push_back(1'b0);
        xwrqst = 1'b1; xwaddr = 32'h100; xwdata_m = 64'h1122334455667788; xwstrb_m = 8'hF0;
        tick();
        xwrqst = 1'b0;
        chk("x_wdata", xwdata, 64'h1122334455667788);
        chk("x_wstrb", 64'(xwstrb), 64'hF0);
        chk("x_aw", 64'({xawprot, xawvalid, xawaddr}), {28'd0, 3'b000, 1'b1, 32'h100});
        xawready = 1'b1; xwready = 1'b1;
        tick();
        xawready = 1'b0; xwready = 1'b0;
        chk("x_bready", 64'({xbready, xwvalid}), 64'h2);
        xbvalid = 1'b1;
        tick();
        xbvalid = 1'b0;
        chk("x_wdone", 64'(xwdone), 64'd1);
        xrd_q.push_back('{64'hFEDCBA9876543210, 1'b0});
        xrrqst = 1'b1; xraddr = 32'h200;
        tick();
        xrrqst = 1'b0;
        chk("x_ar", 64'({xarprot, xarvalid, xaraddr}), {28'd0, 3'b000, 1'b1, 32'h200});
        xarready = 1'b1;
        tick();
        xarready = 1'b0;
        chk("x_rready", 64'(xrready), 64'd1);
        xrvalid = 1'b1; xrdata = 64'hFEDCBA9876543210; xrresp = 2'b00;
        tick();
        xrvalid = 1'b0;
        chk("x_rdone", 64'(xrdone), 64'd1);
        wait_drain("x_drain");
        tick();
        chk("x_idle", 64'({xrbusy, xwbusy}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
